// File: rtl/gps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gps_pkg
//  Description : Shared types and constants for the NMEA sentence controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package gps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_BODY   = 3'd2,
        ST_CS_HI  = 3'd3,
        ST_CS_LO  = 3'd4,
        ST_EOL_CR = 3'd5,
        ST_EOL_LF = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_TRUNC    = 3'd1,
        ERR_BADHEX   = 3'd2,
        ERR_CHKSUM   = 3'd3,
        ERR_EOL      = 3'd4,
        ERR_OVERLONG = 3'd5,
        ERR_UART     = 3'd6
    } err_code_e;

    typedef enum logic [1:0] {
        TYPE_GGA   = 2'd0,
        TYPE_RMC   = 2'd1,
        TYPE_OTHER = 2'd2
    } out_type_e;

    localparam logic [7:0] C_ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] C_ASCII_STAR   = 8'h2A;
    localparam logic [7:0] C_ASCII_CR     = 8'h0D;
    localparam logic [7:0] C_ASCII_LF     = 8'h0A;
    localparam logic [2:0] C_ADDR_LAST    = 3'd4;

    // Only the sentence formatter (last three address characters) matters.
    function automatic out_type_e classify(input logic [23:0] fmt);
        case (fmt)
            24'h474741: classify = TYPE_GGA;
            24'h524D43: classify = TYPE_RMC;
            default:    classify = TYPE_OTHER;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        sat_inc = (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gps_sentence_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gps_sentence_ctrl_if
//  Description : Byte input and sentence-descriptor handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gps_sentence_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       byte_error;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_type;
    logic [7:0] out_len;

    modport master (
        output rx_byte, rx_valid, byte_error, out_ready,
        input  out_valid, out_type, out_len
    );

    modport slave (
        input  rx_byte, rx_valid, byte_error, out_ready,
        output out_valid, out_type, out_len
    );
endinterface
`default_nettype wire

// File: rtl/gps_hex_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : gps_hex_nibble
//  Description : Decodes one upper-case ASCII hex digit into a nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module gps_hex_nibble (
    input  wire  [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_valid
);
    always_comb begin
        o_nibble = 4'd0;
        o_valid  = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nibble = i_char[3:0];
            o_valid  = 1'b1;
        end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
            // 'A'..'F' have low nibbles 1..6
            o_nibble = i_char[3:0] + 4'd9;
            o_valid  = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/gps_sentence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gps_sentence_ctrl
//  Description : NMEA sentence framer/checker with descriptor handshake,
//                rejection reporting, event counters and a stale-fix timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module gps_sentence_ctrl
    import gps_pkg::*;
#(
    parameter int MAX_BYTES      = 128,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  wire               clk,
    input  wire               rst,
    gps_sentence_ctrl_if.slave bus,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [15:0]       good_cnt,
    output logic [15:0]       bad_cnt,
    output logic [15:0]       ovr_cnt,
    output logic              fix_stale
);
    localparam int               C_TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TMR_W-1:0] C_TIMEOUT = C_TMR_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       C_MAX_LEN = 8'(MAX_BYTES);

    state_e              r_state_q,    w_state_d;
    logic [7:0]          r_len_q,      w_len_d;
    logic [7:0]          r_cks_q,      w_cks_d;
    logic [7:0]          r_rx_cs_q,    w_rx_cs_d;
    logic [2:0]          r_addr_cnt_q, w_addr_cnt_d;
    logic [23:0]         r_addr_q,     w_addr_d;
    logic                r_out_valid_q, w_out_valid_d;
    out_type_e           r_out_type_q, w_out_type_d;
    logic [7:0]          r_out_len_q,  w_out_len_d;
    logic                r_err_pulse_q, w_err_pulse_d;
    err_code_e           r_err_code_q, w_err_code_d;
    logic [15:0]         r_good_q,     w_good_d;
    logic [15:0]         r_bad_q,      w_bad_d;
    logic [15:0]         r_ovr_q,      w_ovr_d;
    logic [C_TMR_W-1:0]  r_tmr_q,      w_tmr_d;
    logic                r_stale_q,    w_stale_d;

    logic                w_err;
    err_code_e           w_err_kind;
    logic                w_done;
    logic                w_ovr;
    logic [3:0]          w_hi_nib, w_lo_nib;
    logic                w_hi_ok,  w_lo_ok;

    gps_hex_nibble u_hex_hi (.i_char(bus.rx_byte), .o_nibble(w_hi_nib), .o_valid(w_hi_ok));
    gps_hex_nibble u_hex_lo (.i_char(bus.rx_byte), .o_nibble(w_lo_nib), .o_valid(w_lo_ok));

    // Sentence framing FSM
    always_comb begin
        w_state_d    = r_state_q;
        w_len_d      = r_len_q;
        w_cks_d      = r_cks_q;
        w_rx_cs_d    = r_rx_cs_q;
        w_addr_cnt_d = r_addr_cnt_q;
        w_addr_d     = r_addr_q;
        w_err        = 1'b0;
        w_err_kind   = ERR_NONE;
        w_done       = 1'b0;
        if (bus.byte_error) begin
            if (r_state_q != ST_IDLE) begin
                w_err      = 1'b1;
                w_err_kind = ERR_UART;
                w_state_d  = ST_IDLE;
            end
        end else if (bus.rx_valid) begin
            if (bus.rx_byte == C_ASCII_DOLLAR) begin
                if (r_state_q != ST_IDLE) begin
                    w_err      = 1'b1;
                    w_err_kind = ERR_TRUNC;
                end
                w_state_d    = ST_ADDR;
                w_len_d      = 8'd1;
                w_cks_d      = 8'd0;
                w_addr_cnt_d = 3'd0;
            end else if (r_state_q != ST_IDLE) begin
                if (r_len_q >= C_MAX_LEN) begin
                    w_err      = 1'b1;
                    w_err_kind = ERR_OVERLONG;
                    w_state_d  = ST_IDLE;
                end else begin
                    w_len_d = r_len_q + 8'd1;
                    case (r_state_q)
                        ST_ADDR: begin
                            w_cks_d      = r_cks_q ^ bus.rx_byte;
                            w_addr_d     = {r_addr_q[15:0], bus.rx_byte};
                            w_addr_cnt_d = r_addr_cnt_q + 3'd1;
                            if (r_addr_cnt_q == C_ADDR_LAST) w_state_d = ST_BODY;
                        end
                        ST_BODY: begin
                            if (bus.rx_byte == C_ASCII_STAR) w_state_d = ST_CS_HI;
                            else                             w_cks_d   = r_cks_q ^ bus.rx_byte;
                        end
                        ST_CS_HI: begin
                            if (w_hi_ok) begin
                                w_rx_cs_d = {w_hi_nib, 4'd0};
                                w_state_d = ST_CS_LO;
                            end else begin
                                w_err      = 1'b1;
                                w_err_kind = ERR_BADHEX;
                                w_state_d  = ST_IDLE;
                            end
                        end
                        ST_CS_LO: begin
                            if (w_lo_ok) begin
                                w_rx_cs_d = {r_rx_cs_q[7:4], w_lo_nib};
                                w_state_d = ST_EOL_CR;
                            end else begin
                                w_err      = 1'b1;
                                w_err_kind = ERR_BADHEX;
                                w_state_d  = ST_IDLE;
                            end
                        end
                        ST_EOL_CR: begin
                            if (bus.rx_byte == C_ASCII_CR) begin
                                w_state_d = ST_EOL_LF;
                            end else begin
                                w_err      = 1'b1;
                                w_err_kind = ERR_EOL;
                                w_state_d  = ST_IDLE;
                            end
                        end
                        ST_EOL_LF: begin
                            w_state_d = ST_IDLE;
                            if (bus.rx_byte != C_ASCII_LF) begin
                                w_err      = 1'b1;
                                w_err_kind = ERR_EOL;
                            end else if (r_rx_cs_q != r_cks_q) begin
                                w_err      = 1'b1;
                                w_err_kind = ERR_CHKSUM;
                            end else begin
                                w_done = 1'b1;
                            end
                        end
                        default: w_state_d = ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Descriptor handshake, error reporting, counters and stale timer
    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_type_d  = r_out_type_q;
        w_out_len_d   = r_out_len_q;
        w_ovr         = 1'b0;
        if (w_done) begin
            if (!r_out_valid_q || bus.out_ready) begin
                w_out_valid_d = 1'b1;
                w_out_type_d  = classify(r_addr_q);
                w_out_len_d   = w_len_d;
            end else begin
                w_ovr = 1'b1;
            end
        end else if (r_out_valid_q && bus.out_ready) begin
            w_out_valid_d = 1'b0;
        end

        w_err_pulse_d = w_err;
        w_err_code_d  = w_err ? w_err_kind : r_err_code_q;
        w_good_d      = sat_inc(r_good_q, w_done);
        w_bad_d       = sat_inc(r_bad_q, w_err);
        w_ovr_d       = sat_inc(r_ovr_q, w_ovr);

        w_tmr_d   = r_tmr_q;
        w_stale_d = r_stale_q;
        if (w_done) begin
            w_tmr_d   = '0;
            w_stale_d = 1'b0;
        end else if (r_tmr_q != C_TIMEOUT) begin
            w_tmr_d   = r_tmr_q + C_TMR_W'(1);
            w_stale_d = r_stale_q || (w_tmr_d == C_TIMEOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_len_q       <= 8'd0;
            r_cks_q       <= 8'd0;
            r_rx_cs_q     <= 8'd0;
            r_addr_cnt_q  <= 3'd0;
            r_addr_q      <= 24'd0;
            r_out_valid_q <= 1'b0;
            r_out_type_q  <= TYPE_GGA;
            r_out_len_q   <= 8'd0;
            r_err_pulse_q <= 1'b0;
            r_err_code_q  <= ERR_NONE;
            r_good_q      <= 16'd0;
            r_bad_q       <= 16'd0;
            r_ovr_q       <= 16'd0;
            r_tmr_q       <= '0;
            r_stale_q     <= 1'b1;
        end else begin
            r_state_q     <= w_state_d;
            r_len_q       <= w_len_d;
            r_cks_q       <= w_cks_d;
            r_rx_cs_q     <= w_rx_cs_d;
            r_addr_cnt_q  <= w_addr_cnt_d;
            r_addr_q      <= w_addr_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_type_q  <= w_out_type_d;
            r_out_len_q   <= w_out_len_d;
            r_err_pulse_q <= w_err_pulse_d;
            r_err_code_q  <= w_err_code_d;
            r_good_q      <= w_good_d;
            r_bad_q       <= w_bad_d;
            r_ovr_q       <= w_ovr_d;
            r_tmr_q       <= w_tmr_d;
            r_stale_q     <= w_stale_d;
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.out_type  = r_out_type_q;
    assign bus.out_len   = r_out_len_q;
    assign err_pulse     = r_err_pulse_q;
    assign err_code      = r_err_code_q;
    assign good_cnt      = r_good_q;
    assign bad_cnt       = r_bad_q;
    assign ovr_cnt       = r_ovr_q;
    assign fix_stale     = r_stale_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_sentence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gps_sentence_ctrl
//  Description : Self-checking bench for gps_sentence_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gps_sentence_ctrl;
    import gps_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [15:0] good_cnt, bad_cnt, ovr_cnt;
    logic        fix_stale;

    int n_checks = 0;
    int n_errors = 0;
    int exp_good = 0;
    int exp_bad  = 0;
    int exp_ovr  = 0;

    typedef struct {
        logic [1:0] t;
        logic [7:0] len;
    } desc_t;

    typedef struct {
        string      s;
        bit         good;
        logic [1:0] t;
        logic [2:0] err;
    } vec_t;

    desc_t      desc_q[$];
    logic [2:0] err_q[$];
    vec_t       vecs[13];
    string      crs, lfs, crlf;

    always #5 clk = ~clk;

    gps_sentence_ctrl_if bus();

    gps_sentence_ctrl #(.MAX_BYTES(128), .TIMEOUT_CYCLES(50)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt),
        .ovr_cnt   (ovr_cnt),
        .fix_stale (fix_stale)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // Scoreboard: descriptors popped on handshake, rejections popped on err_pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (desc_q.size() == 0) unexpected("desc");
                else begin
                    desc_t d;
                    d = desc_q.pop_front();
                    check("desc_type", {30'd0, bus.out_type}, {30'd0, d.t});
                    check("desc_len", {24'd0, bus.out_len}, {24'd0, d.len});
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) unexpected("err_pulse");
                else begin
                    logic [2:0] e;
                    e = err_q.pop_front();
                    check("err_code", {29'd0, err_code}, {29'd0, e});
                end
            end
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        hexc = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    function automatic string with_cs(input string body);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < body.len(); i++) x = x ^ body[i];
        with_cs = $sformatf("$%s*%c%c%c%c", body, hexc(x[7:4]), hexc(x[3:0]), 8'h0D, 8'h0A);
    endfunction

    function automatic string rep(input logic [7:0] c, input int n);
        rep = "";
        for (int i = 0; i < n; i++) rep = $sformatf("%s%c", rep, c);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        idle(gap);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_good_cnt"}, {16'd0, good_cnt}, exp_good);
        check({tag, "_bad_cnt"},  {16'd0, bad_cnt},  exp_bad);
        check({tag, "_ovr_cnt"},  {16'd0, ovr_cnt},  exp_ovr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        string sA, sB, sC, sD, s;

        crs  = $sformatf("%c", 8'h0D);
        lfs  = $sformatf("%c", 8'h0A);
        crlf = {crs, lfs};

        vecs[0]  = '{{"$GPRMC,A*26", crlf},             1'b1, 2'd1, 3'd0};
        vecs[1]  = '{{"$GPRMC,A*27", crlf},             1'b0, 2'd0, 3'd3};
        vecs[2]  = '{with_cs("GNGGA,123,4"),            1'b1, 2'd0, 3'd0};
        vecs[3]  = '{with_cs("GPGSV,1"),                1'b1, 2'd2, 3'd0};
        vecs[4]  = '{with_cs("GPRMC"),                  1'b1, 2'd1, 3'd0};
        vecs[5]  = '{{"$GPRMC,A*2G", crlf},             1'b0, 2'd0, 3'd2};
        vecs[6]  = '{{"$GPRMC,A*g6", crlf},             1'b0, 2'd0, 3'd2};
        vecs[7]  = '{{"$GPRMC,A*26", lfs},              1'b0, 2'd0, 3'd4};
        vecs[8]  = '{{"$GPRMC,A*26", crs, "X"},         1'b0, 2'd0, 3'd4};
        vecs[9]  = '{with_cs({"GPTXT", rep(8'h41, 117)}), 1'b1, 2'd2, 3'd0};
        vecs[10] = '{with_cs({"GPTXT", rep(8'h41, 118)}), 1'b0, 2'd0, 3'd5};
        vecs[11] = '{{"$GPTXT", rep(8'h41, 124)},       1'b0, 2'd0, 3'd5};
        vecs[12] = '{with_cs("GPGGA,1"),                1'b1, 2'd0, 3'd0};

        rst            = 1'b1;
        bus.rx_byte    = 8'd0;
        bus.rx_valid   = 1'b0;
        bus.byte_error = 1'b0;
        bus.out_ready  = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_type",  {30'd0, bus.out_type}, 0);
        check("rst_out_len",   {24'd0, bus.out_len}, 0);
        check("rst_err_pulse", {31'd0, err_pulse}, 0);
        check("rst_err_code",  {29'd0, err_code}, 0);
        check("rst_fix_stale", {31'd0, fix_stale}, 1);
        check_counters("rst");

        // Table-driven sentences
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].good) begin
                desc_q.push_back('{vecs[i].t, 8'(vecs[i].s.len())});
                exp_good++;
            end else begin
                err_q.push_back(vecs[i].err);
                exp_bad++;
            end
            send_str(vecs[i].s, 3);
            check_counters($sformatf("vec%0d", i));
            check($sformatf("vec%0d_drained", i), desc_q.size() + err_q.size(), 0);
        end

        // Descriptor appears exactly one cycle after the LF strobe
        s = {"$GPRMC,A*26", crlf};
        desc_q.push_back('{2'd1, 8'd13});
        exp_good++;
        for (int i = 0; i < 12; i++) send_byte(s[i]);
        bus.rx_byte  = 8'h0A;
        bus.rx_valid = 1'b1;
        #2;
        check("lat_before_edge", {31'd0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("lat_valid",  {31'd0, bus.out_valid}, 1);
        check("lat_type",   {30'd0, bus.out_type}, 1);
        check("lat_len",    {24'd0, bus.out_len}, 13);
        check("lat_good",   {16'd0, good_cnt}, exp_good);
        idle(2);

        // Truncated sentence restarts on the new '$'
        err_q.push_back(3'd1);
        desc_q.push_back('{2'd1, 8'd13});
        exp_bad++;
        exp_good++;
        send_str({"$GPGG$GPRMC,A*26", crlf}, 3);
        check_counters("trunc");

        // UART error mid-sentence wins over a simultaneous byte
        err_q.push_back(3'd6);
        exp_bad++;
        send_str("$GPR", 0);
        bus.byte_error = 1'b1;
        send_byte(8'h4D);
        bus.byte_error = 1'b0;
        send_str({"MC,A*26", crlf}, 3);
        // In IDLE the error is ignored and the '$' it carries is discarded
        bus.byte_error = 1'b1;
        send_byte(8'h24);
        bus.byte_error = 1'b0;
        send_str({"GPRMC,A*26", crlf}, 3);
        check_counters("uart");
        check("uart_err_code", {29'd0, err_code}, 6);

        // Overrun: second completion dropped while first is pending
        bus.out_ready = 1'b0;
        sA = with_cs("GPGGA,7");
        sB = with_cs("GPRMC,9");
        desc_q.push_back('{2'd0, 8'(sA.len())});
        exp_good += 2;
        exp_ovr++;
        send_str(sA, 2);
        send_str(sB, 2);
        check_counters("ovr");
        check("ovr_valid", {31'd0, bus.out_valid}, 1);
        check("ovr_type",  {30'd0, bus.out_type}, 0);
        check("ovr_len",   {24'd0, bus.out_len}, sA.len());
        bus.out_ready = 1'b1;
        idle(1);
        check("ovr_release", {31'd0, bus.out_valid}, 0);

        // Completion coinciding with a handshake loads the new descriptor
        bus.out_ready = 1'b0;
        sC = with_cs("GPGGA,3");
        sD = with_cs("GNXYZ,5");
        desc_q.push_back('{2'd0, 8'(sC.len())});
        exp_good += 2;
        send_str(sC, 2);
        for (int i = 0; i < sD.len() - 1; i++) send_byte(sD[i]);
        bus.out_ready = 1'b1;
        desc_q.push_back('{2'd2, 8'(sD.len())});
        send_byte(8'h0A);
        bus.out_ready = 1'b0;
        check("coin_valid", {31'd0, bus.out_valid}, 1);
        check("coin_type",  {30'd0, bus.out_type}, 2);
        check("coin_len",   {24'd0, bus.out_len}, sD.len());
        check("coin_stale", {31'd0, fix_stale}, 0);
        bus.out_ready = 1'b1;
        idle(2);
        check_counters("coin");

        // Stale timer: 50 cycles after the last good completion
        idle(38);
        check("stale_40", {31'd0, fix_stale}, 0);
        idle(12);
        check("stale_52", {31'd0, fix_stale}, 1);

        // Reset mid-body discards the partial sentence silently
        send_str("$GPRMC,AB", 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        exp_ovr  = 0;
        check("rstmid_err_pulse", {31'd0, err_pulse}, 0);
        check("rstmid_stale", {31'd0, fix_stale}, 1);
        check_counters("rstmid");
        desc_q.push_back('{2'd1, 8'd13});
        exp_good++;
        send_str({"$GPRMC,A*26", crlf}, 3);
        check_counters("post_rst");

        check("final_desc_q", desc_q.size(), 0);
        check("final_err_q", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gps_sentence_ctrl.md
GPS_SENTENCE_CTRL -- requirements
Module: gps_sentence_ctrl

Interface
REQ-001 Parameter MAX_BYTES, 128: maximum sentence length in bytes, counted from '$' through LF inclusive.
REQ-002 Parameter TIMEOUT_CYCLES, 200_000_000: cycles with no good sentence before fix_stale asserts (2 s at 100 MHz).
REQ-003 clk  in  1  100 MHz system clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_byte  in  8  received UART byte; valid only while rx_valid=1.
REQ-006 rx_valid  in  1  one-cycle strobe per received byte.
REQ-007 byte_error  in  1  one-cycle UART framing-error strobe.
REQ-008 out_valid  out  1  a completed, checksum-good sentence descriptor is pending.
REQ-009 out_ready  in  1  consumer accepts the descriptor.
REQ-010 out_type  out  2  message type: 0=GGA, 1=RMC, 2=OTHER.
REQ-011 out_len  out  8  sentence length in bytes.
REQ-012 err_pulse  out  1  one-cycle strobe when a sentence is rejected.
REQ-013 err_code  out  3  reason for the last rejection; held between rejections.
REQ-014 good_cnt / bad_cnt / ovr_cnt  out  16 each  saturating event counters.
REQ-015 fix_stale  out  1  no good sentence has completed within TIMEOUT_CYCLES.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, BODY, CS_HI, CS_LO, EOL_CR and EOL_LF, and SHALL advance only on rx_valid.
REQ-017 Transitions:
- IDLE: '$' -> ADDR; length=1; checksum=0.
- ADDR: stores exactly 5 address characters -> BODY.
- BODY: on '*' -> CS_HI.
- CS_HI: one hex digit -> CS_LO.
- CS_LO: one hex digit -> EOL_CR.
- EOL_CR: CR -> EOL_LF.
- EOL_LF: LF -> complete; FSM returns to IDLE.
REQ-018 The checksum SHALL be the XOR of every byte strictly between '$' and '*', including the ADDR bytes.
REQ-019 Hex digits SHALL accept only '0'-'9' and 'A'-'F'; the first digit is the high nibble.
REQ-020 Rejection codes:
- 1 = TRUNC: '$' received outside IDLE. FSM restarts in ADDR with the new sentence.
- 2 = BADHEX: invalid hex digit.
- 3 = CHKSUM: checksum mismatch, detected at LF.
- 4 = EOL: wrong byte in EOL_CR or EOL_LF.
- 5 = OVERLONG: a byte would make length exceed MAX_BYTES.
- 6 = UART: byte_error while not in IDLE.
REQ-021 Except for TRUNC, every rejection SHALL return the FSM to IDLE.
REQ-022 Every rejection SHALL pulse err_pulse and increment bad_cnt; byte_error in IDLE SHALL be ignored.
REQ-023 If byte_error and rx_valid occur in the same cycle, byte_error SHALL win and the byte SHALL be discarded.
REQ-024 out_type SHALL be derived from ADDR characters 3-5: "GGA"=0, "RMC"=1, anything else=2. Talker characters 1-2 are ignored.
REQ-025 When a good sentence completes, out_valid SHALL assert in the cycle after the LF strobe, and good_cnt SHALL increment.
REQ-026 out_valid, out_type and out_len SHALL remain stable until the cycle after out_valid & out_ready.
REQ-027 If a good sentence completes while a descriptor is pending and out_ready=0, the new sentence SHALL be dropped, the old descriptor kept, and ovr_cnt incremented.
REQ-028 If a completion coincides with out_valid & out_ready, the new descriptor SHALL load and out_valid SHALL stay 1.
REQ-029 Counters SHALL saturate at 16'hFFFF.
REQ-030 The stale timer SHALL clear on each good completion. fix_stale SHALL assert when the timer reaches TIMEOUT_CYCLES and SHALL deassert on the cycle after the next good completion.

Reset
REQ-031 On rst, the block SHALL set:
- state=IDLE;
- out_valid=0, out_type=0, out_len=0;
- err_pulse=0, err_code=0;
- all counters=0;
- stale timer=0, fix_stale=1.
REQ-032 rst mid-sentence SHALL discard the partial sentence without any error pulse or counter increment.

Structure
REQ-033 Package gps_pkg SHALL hold:
- the state enum;
- the err_code enum;
- the out_type enum;
- the ASCII constants '$', '*', CR and LF.
REQ-034 A single combinational sub-module, gps_hex_nibble (ASCII in; nibble and valid out), SHALL be instantiated twice, once per checksum digit.

Verification
REQ-035 "$GPRMC,A*26\r\n" -> out_valid asserts one cycle after LF, out_type=1, out_len=13, good_cnt=1.
REQ-036 "$GPRMC,A*27\r\n" -> err_pulse once at LF, err_code=3, bad_cnt=1, out_valid stays 0.
REQ-037 "$GPGG$GPRMC,A*26\r\n" -> err_code=1 at the second '$', then a good RMC descriptor with out_len=13.
REQ-038 Two valid sentences with out_ready=0 -> first descriptor retained, ovr_cnt=1; raise out_ready -> out_valid falls the next cycle.
REQ-039 TIMEOUT_CYCLES=50:
- after reset, fix_stale=1;
- one good sentence -> fix_stale=0;
- 50 idle cycles -> fix_stale=1.
REQ-040 A 130-byte body with MAX_BYTES=128 -> err_code=5 on byte 129 and FSM in IDLE; rst during BODY -> no error pulse, counters unchanged.
